// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encodings, error codes, parity helper, command bytes.
package ps2_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_PARITY    = 3'd4;
    localparam logic [2:0] ST_STOP      = 3'd5;
    localparam logic [2:0] ST_ACK       = 3'd6;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd7;

    typedef enum logic [2:0] {
        PS2_TX_IDLE      = ST_IDLE,
        PS2_TX_INHIBIT   = ST_INHIBIT,
        PS2_TX_RELEASE   = ST_RELEASE,
        PS2_TX_SHIFT     = ST_SHIFT,
        PS2_TX_PARITY    = ST_PARITY,
        PS2_TX_STOP      = ST_STOP,
        PS2_TX_ACK       = ST_ACK,
        PS2_TX_WAIT_IDLE = ST_WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [1:0] PS2_ERR_OK      = 2'd0;
    localparam logic [1:0] PS2_ERR_NOACK   = 2'd1;
    localparam logic [1:0] PS2_ERR_TIMEOUT = 2'd2;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter: the output follows the line only
// after the synchronised level has differed from it for FILTER_LEN consecutive cycles.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic line_o
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, LSB-first byte, odd parity, stop, ack check.
// Optional macro PS2_HOST_TX_TIMEOUT_EN adds the start/frame timeout counters (err = TIMEOUT).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned FRAME_TIMEOUT  = 100000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    ps2_tx_state_t state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   inh_q, inh_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          clk_prev_q;
    logic          clk_f, dat_f, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i   (CLOCK_50),
        .rst_n_i (RESET_N),
        .line_i  (ps2_clk_in),
        .line_o  (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk_i   (CLOCK_50),
        .rst_n_i (RESET_N),
        .line_i  (ps2_dat_in),
        .line_o  (dat_f)
    );

    assign fall = clk_prev_q & ~clk_f;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] tmo_lim;
`else
    // Timeout limits have no effect in this build; referenced only to keep the interface.
    if (START_TIMEOUT == 0 || FRAME_TIMEOUT == 0) begin : g_tmo_unused
    end
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_d    = par_q;
        cnt_d    = cnt_q;
        inh_d    = inh_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            PS2_TX_IDLE: begin
                if (tx_valid) begin
                    data_d   = tx_data;
                    par_d    = ps2_odd_parity(tx_data);
                    cnt_d    = '0;
                    inh_d    = '0;
                    clk_oe_d = 1'b1;
                    dat_oe_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = PS2_TX_INHIBIT;
                end
            end
            PS2_TX_INHIBIT: begin
                if (inh_q == INHIBIT_CYCLES - 1) begin
                    dat_oe_d = 1'b1;
                    state_d  = PS2_TX_RELEASE;
                end else begin
                    inh_d = inh_q + 32'd1;
                end
            end
            PS2_TX_RELEASE: begin
                clk_oe_d = 1'b0;
                if (fall) begin
                    dat_oe_d = ~data_q[0];
                    cnt_d    = cnt_q + 4'd1;
                    state_d  = PS2_TX_SHIFT;
                end
            end
            PS2_TX_SHIFT: begin
                // cnt_q holds the edges seen so far, which is also the next bit index.
                if (fall) begin
                    dat_oe_d = ~data_q[cnt_q[2:0]];
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) state_d = PS2_TX_PARITY;
                end
            end
            PS2_TX_PARITY: begin
                if (fall) begin
                    dat_oe_d = ~par_q;
                    cnt_d    = cnt_q + 4'd1;
                    state_d  = PS2_TX_STOP;
                end
            end
            PS2_TX_STOP: begin
                if (fall) begin
                    dat_oe_d = 1'b0;
                    cnt_d    = cnt_q + 4'd1;
                    state_d  = PS2_TX_ACK;
                end
            end
            PS2_TX_ACK: begin
                if (fall) begin
                    cnt_d   = cnt_q + 4'd1;
                    err_d   = dat_f ? PS2_ERR_NOACK : PS2_ERR_OK;
                    state_d = PS2_TX_WAIT_IDLE;
                end
            end
            PS2_TX_WAIT_IDLE: begin
                if (clk_f && dat_f) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = PS2_TX_IDLE;
                end
            end
            default: state_d = PS2_TX_IDLE;
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        tmo_d   = tmo_q;
        tmo_lim = (state_q == PS2_TX_RELEASE) ? START_TIMEOUT : FRAME_TIMEOUT;
        if (!(state_q inside {PS2_TX_RELEASE, PS2_TX_SHIFT, PS2_TX_PARITY,
                              PS2_TX_STOP, PS2_TX_ACK})) begin
            tmo_d = '0;
        end else if (state_q == PS2_TX_RELEASE && fall) begin
            tmo_d = '0;
        end else if (tmo_q == tmo_lim) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            err_d    = PS2_ERR_TIMEOUT;
            state_d  = PS2_TX_IDLE;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q    <= PS2_TX_IDLE;
            data_q     <= '0;
            par_q      <= 1'b0;
            cnt_q      <= '0;
            inh_q      <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= PS2_ERR_OK;
            clk_prev_q <= 1'b1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_q      <= par_d;
            cnt_q      <= cnt_d;
            inh_q      <= inh_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            clk_prev_q <= clk_f;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign tx_ready   = (state_q == PS2_TX_IDLE);
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on wired-AND pads.
// Timeout expectations follow PS2_HOST_TX_TIMEOUT_EN.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH = 5000;
    localparam int unsigned FL  = 8;
    localparam int unsigned ST  = 2000;
    localparam int unsigned FT  = 5000;
    localparam int unsigned H   = 40;   // device clock half-period, scaled down

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, clk_oe, dat_oe, busy, done;
    logic [1:0] err;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       clk_line, dat_line;

    int compared = 0;
    int mismatched = 0;
    int done_cnt = 0;
    int dbl_cnt = 0;
    logic [1:0] last_err = '0;
    logic busy_at_done = 1'b0;
    logic prev_done = 1'b0;

    assign clk_line = dev_clk & ~clk_oe;
    assign dat_line = dev_dat & ~dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .FILTER_LEN     (FL),
        .START_TIMEOUT  (ST),
        .FRAME_TIMEOUT  (FT)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (clk_oe),
        .ps2_dat_oe (dat_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            last_err = err;
            busy_at_done = busy;
            if (prev_done === 1'b1) dbl_cnt++;
        end
        prev_done = done;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame the device should observe: start(0) implied, data LSB first, odd parity, stop 1.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, p, d};
    endfunction

    task automatic start_xfer(input logic [7:0] d, input string tag);
        int k;
        @(negedge clk);
        compared++;
        if (tx_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_ready: got %b want 1", tag, tx_ready);
        end
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        compared++;
        if (clk_oe !== 1'b1 || busy !== 1'b1 || tx_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_accept: clk_oe=%b busy=%b ready=%b want 1 1 0", tag, clk_oe, busy, tx_ready);
        end
        k = 0;
        while (dat_oe !== 1'b1 && k < int'(INH) + 100) begin
            if (clk_oe === 1'b1) k++;
            @(negedge clk);
        end
        compared++;
        if (k != int'(INH) || clk_oe !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_inhibit: clk-low cycles=%0d clk_oe=%b want %0d 1", tag, k, clk_oe, INH);
        end
        @(negedge clk);
        compared++;
        if (clk_oe !== 1'b0 || dat_oe !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_release: clk_oe=%b dat_oe=%b want 0 1", tag, clk_oe, dat_oe);
        end
    endtask

    task automatic device_frame(input logic ack, output logic [9:0] bits, input string tag);
        repeat (30) @(negedge clk);
        compared++;
        if (clk_line !== 1'b1 || dat_line !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_start: clk=%b dat=%b want 1 0", tag, clk_line, dat_line);
        end
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            bits[i] = dat_line;
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        if (ack) dev_dat = 1'b0;
        repeat (H / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H / 2) @(negedge clk);
        dev_dat = 1'b1;
    endtask

    task automatic finish_xfer(input int n0, input logic [1:0] exp_err, input string tag);
        int k;
        k = 0;
        while (done_cnt == n0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (done_cnt != n0 + 1 || last_err !== exp_err || busy_at_done !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_done: dones=%0d err=%0d busy=%b want %0d %0d 0",
                     tag, done_cnt - n0, last_err, busy_at_done, 1, exp_err);
        end
        @(negedge clk);
        compared++;
        if (tx_ready !== 1'b1 || clk_oe !== 1'b0 || dat_oe !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_idle: ready=%b clk_oe=%b dat_oe=%b done=%b want 1 0 0 0",
                     tag, tx_ready, clk_oe, dat_oe, done);
        end
    endtask

    task automatic test_send(input logic [7:0] d, input logic ack, input string tag);
        logic [9:0] bits;
        logic [9:0] exp;
        int n0;
        n0 = done_cnt;
        exp = model_frame(d);
        start_xfer(d, tag);
        device_frame(ack, bits, tag);
        compared++;
        if (bits !== exp) begin
            mismatched++;
            $display("FAIL %s_bits: got %b want %b", tag, bits, exp);
        end
        finish_xfer(n0, ack ? PS2_ERR_OK : PS2_ERR_NOACK, tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 2'd0 ||
            clk_oe !== 1'b0 || dat_oe !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b err=%0d clk_oe=%b dat_oe=%b want 1 0 0 0 0 0",
                     tx_ready, busy, done, err, clk_oe, dat_oe);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_timeout();
        int k;
        int n0;
        n0 = done_cnt;
        start_xfer(8'h5A, "tmo");
`ifdef PS2_HOST_TX_TIMEOUT_EN
        k = 0;
        while (done !== 1'b1 && k < int'(ST) + 100) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (k != int'(ST) || err !== PS2_ERR_TIMEOUT || busy !== 1'b0 ||
            clk_oe !== 1'b0 || dat_oe !== 1'b0) begin
            mismatched++;
            $display("FAIL tmo_start: cycles=%0d err=%0d busy=%b clk_oe=%b dat_oe=%b want %0d 2 0 0 0",
                     k, err, busy, clk_oe, dat_oe, ST);
        end
        @(negedge clk);
        compared++;
        if (tx_ready !== 1'b1 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL tmo_idle: ready=%b done=%b want 1 0", tx_ready, done);
        end
`else
        k = 0;
        repeat (ST + 100) @(negedge clk);
        compared++;
        if (busy !== 1'b1 || done_cnt != n0 || dat_oe !== 1'b1 || k != 0) begin
            mismatched++;
            $display("FAIL tmo_wait: busy=%b dones=%0d dat_oe=%b want 1 0 1", busy, done_cnt - n0, dat_oe);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
`endif
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int n0;
        d = 8'($urandom);
        n0 = done_cnt;
        start_xfer(d, "rstmid");
        repeat (30) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (i < 4) begin
                dev_clk = 1'b1;
                repeat (H) @(negedge clk);
            end
        end
        compared++;
        if (dat_oe !== ~d[4]) begin
            mismatched++;
            $display("FAIL rstmid_bit4: dat_oe=%b want %b", dat_oe, ~d[4]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if (clk_oe !== 1'b0 || dat_oe !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_release: clk_oe=%b dat_oe=%b ready=%b busy=%b want 0 0 1 0",
                     clk_oe, dat_oe, tx_ready, busy);
        end
        rst_n = 1'b1;
        dev_clk = 1'b1;
        repeat (60) @(negedge clk);
        compared++;
        if (done_cnt != n0) begin
            mismatched++;
            $display("FAIL rstmid_nodone: dones=%0d want 0", done_cnt - n0);
        end
        test_send(PS2_CMD_RESET, 1'b1, "ff");
    endtask

    task automatic test_ignore_valid();
        logic [9:0] bits;
        logic [7:0] d;
        int n0;
        d = 8'($urandom);
        n0 = done_cnt;
        start_xfer(d, "ign");
        compared++;
        if (tx_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL ign_ready: got %b want 0", tx_ready);
        end
        tx_valid = 1'b1;
        tx_data = ~d;
        @(negedge clk);
        tx_valid = 1'b0;
        device_frame(1'b1, bits, "ign");
        compared++;
        if (bits !== model_frame(d)) begin
            mismatched++;
            $display("FAIL ign_bits: got %b want %b", bits, model_frame(d));
        end
        finish_xfer(n0, PS2_ERR_OK, "ign");
        repeat (300) @(negedge clk);
        compared++;
        if (clk_oe !== 1'b0 || busy !== 1'b0 || done_cnt != n0 + 1) begin
            mismatched++;
            $display("FAIL ign_second: clk_oe=%b busy=%b dones=%0d want 0 0 1", clk_oe, busy, done_cnt - n0);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic ack;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            test_send(d, ack, "rand");
        end
    endtask

    task automatic test_done_width();
        compared++;
        if (dbl_cnt != 0) begin
            mismatched++;
            $display("FAIL done_width: multi-cycle done pulses=%0d want 0", dbl_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_send(PS2_CMD_SET_LEDS, 1'b1, "ed");
        test_send(8'h01, 1'b1, "x01");
        test_send(8'h00, 1'b1, "x00");
        test_send(8'hA7, 1'b0, "noack");
        test_timeout();
        test_reset_midframe();
        test_ignore_valid();
        test_random();
        test_done_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
